external_block_pipelined: RTL

Parametrised successor to the single-outstanding external-block bus model. It accepts a new request on any cycle and queues up to DEPTH outstanding requests, each with its own response delay. Responses complete strictly in order, at most one per cycle. It is the far-side target for regblock external-interface tests that need pipelined, back-to-back traffic and full/overflow corner cases.

---
 rtl/external_block_pipelined.sv | 132 +++++++++++++
 1 files changed

// File: rtl/external_block_pipelined.sv
// Pipelined external-block bus target: up to DEPTH in-order outstanding requests, each with its own response delay.
// Optional pseudo-random per-request delay: define EXTERNAL_BLOCK_PIPELINED_RAND_DELAY_EN.
module external_block_pipelined #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int MIN_DELAY  = 0,
    parameter int MAX_DELAY  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         req_is_wr,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [WIDTH-1:0]             wr_biten,
    output logic                         rd_ack,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         wr_ack,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);
    localparam int BYTE_W  = $clog2(WIDTH / 8);
    localparam int IDX_W   = ADDR_WIDTH - BYTE_W;
    localparam int WORDS   = 2 ** IDX_W;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int DLY_TOP = (MAX_DELAY > MIN_DELAY) ? MAX_DELAY : MIN_DELAY;
    localparam int CNT_W   = (DLY_TOP > 0) ? $clog2(DLY_TOP + 1) : 1;

    logic             q_is_wr [DEPTH];
    logic [IDX_W-1:0] q_idx   [DEPTH];
    logic [WIDTH-1:0] q_data  [DEPTH];
    logic [WIDTH-1:0] q_biten [DEPTH];
    logic [CNT_W-1:0] q_cnt   [DEPTH];
    logic [WIDTH-1:0] mem     [WORDS];

    logic [PTR_W-1:0] head, tail;
    logic [OCC_W-1:0] occ;
    logic             overflow_q;
    logic             rd_vld_p0, wr_vld_p0;
    logic [WIDTH-1:0] rd_data_p0;

    logic             pop, push, full;
    logic [IDX_W-1:0] req_idx;
    logic [CNT_W-1:0] req_dly;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef EXTERNAL_BLOCK_PIPELINED_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Advances only on accepted requests so the delay sequence is a pure function of request order.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (push)
            lfsr <= {lfsr[14:0], lfsr_fb};
    end

    always_comb begin
        req_dly = CNT_W'(MIN_DELAY + int'(lfsr) % (MAX_DELAY - MIN_DELAY + 1));
    end
`else
    always_comb begin
        req_dly = CNT_W'(MIN_DELAY);
    end
`endif

    always_comb begin
        req_idx = IDX_W'(addr >> BYTE_W);
        full    = (occ == OCC_W'(DEPTH));
        pop     = (occ != '0) && (q_cnt[head] == '0);
        // A pop frees a slot in the same edge, so a full queue still accepts when it is draining.
        push    = req && (!full || pop);
    end

    // Stage p0: pop issue into memory and the ack/read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            overflow_q <= 1'b0;
            rd_vld_p0  <= 1'b0;
            wr_vld_p0  <= 1'b0;
            rd_data_p0 <= '0;
            for (int i = 0; i < DEPTH; i++) q_cnt[i] <= '0;
            for (int w = 0; w < WORDS; w++) mem[w] <= '0;
        end else begin
            rd_vld_p0  <= pop && !q_is_wr[head];
            wr_vld_p0  <= pop && q_is_wr[head];
            rd_data_p0 <= (pop && !q_is_wr[head]) ? mem[q_idx[head]] : '0;
            if (pop && q_is_wr[head])
                mem[q_idx[head]] <= (mem[q_idx[head]] & ~q_biten[head]) |
                                    (q_data[head] & q_biten[head]);
            if (pop)  head <= ptr_inc(head);
            if (push) tail <= ptr_inc(tail);
            if (push && !pop)
                occ <= occ + 1'b1;
            else if (pop && !push)
                occ <= occ - 1'b1;
            if (req && !push) overflow_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && tail == PTR_W'(i))
                    q_cnt[i] <= req_dly;
                else if (q_cnt[i] != '0)
                    q_cnt[i] <= q_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_is_wr[tail] <= req_is_wr;
            q_idx[tail]   <= req_idx;
            q_data[tail]  <= wr_data;
            q_biten[tail] <= wr_biten;
        end
    end

    assign rd_ack      = rd_vld_p0;
    assign wr_ack      = wr_vld_p0;
    assign rd_data     = rd_data_p0;
    assign overflow    = overflow_q;
    assign outstanding = occ;
endmodule
